// File: rtl/neopixel_tx.sv
// WS2812 (NeoPixel) frame transmitter: reads a window of RGB words from the pixel
// memory, reorders to GRB and serialises MSB first, then holds the latch low period.
module neopixel_tx #(
  parameter int unsigned NUM_PIXELS   = 8,
  parameter logic [7:0]  BASE_ADDR    = 8'd8,
  parameter int unsigned T0H          = 20,
  parameter int unsigned T1H          = 40,
  parameter int unsigned TBIT         = 63,
  parameter int unsigned RESET_CYCLES = 15000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_pix_addr,
  input  logic [23:0] i_pix_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SEND  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  localparam logic [19:0] TBIT_LAST  = 20'(TBIT - 1);
  localparam logic [19:0] LATCH_LAST = 20'(RESET_CYCLES - 1);
  localparam logic [19:0] T0H_C      = 20'(T0H);
  localparam logic [19:0] T1H_C      = 20'(T1H);
  localparam logic [8:0]  NUM_PIX_C  = 9'(NUM_PIXELS);

  state_t      state_q, state_d;
  logic [19:0] cyc_cnt_q, cyc_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  pix_idx_q, pix_idx_d;
  logic [7:0]  addr_q, addr_d;
  logic [23:0] shift_q, shift_d;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [23:0] rgb_to_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pix_idx_d = pix_idx_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d    = BASE_ADDR;
        cyc_cnt_d = '0;
        bit_cnt_d = '0;
        pix_idx_d = '0;
        if (i_start) state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d   = rgb_to_grb(i_pix_data);
        pix_idx_d = 9'd1;
        addr_d    = addr_q + 8'd1;
        bit_cnt_d = '0;
        cyc_cnt_d = '0;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (cyc_cnt_q == TBIT_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q != 5'd23) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else if (pix_idx_q < NUM_PIX_C) begin
            // Next pixel is fetched on the last cycle of the previous one: no gap cycle.
            shift_d   = rgb_to_grb(i_pix_data);
            pix_idx_d = pix_idx_q + 9'd1;
            addr_d    = addr_q + 8'd1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = '0;
            state_d   = S_LATCH;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 20'd1;
        end
      end

      S_LATCH: begin
        if (cyc_cnt_q == LATCH_LAST) begin
          cyc_cnt_d = '0;
          addr_d    = BASE_ADDR;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 20'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    // Line level follows the next cycle's bit/count so the registered output lines up with it.
    dout_d = (state_d == S_SEND) &&
             (cyc_cnt_d < (shift_d[23] ? T1H_C : T0H_C));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      pix_idx_q <= '0;
      addr_q    <= BASE_ADDR;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      pix_idx_q <= pix_idx_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
    shift_q <= shift_d;
  end

  assign o_pix_addr = addr_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_dout     = dout_q;

endmodule

// File: tb/tb_neopixel_tx.sv
// Bench for neopixel_tx: two instances (1 pixel @ base 8, 2 pixels @ base 255) share a
// pixel memory; a per-cycle expected waveform queue is consumed by a negedge monitor.
module tb_neopixel_tx;

  localparam int T0H = 2;
  localparam int T1H = 4;
  localparam int TBIT = 6;
  localparam int RST_CYC = 10;
  localparam int NP_A = 1;
  localparam int NP_B = 2;
  localparam logic [7:0] BA_A = 8'd8;
  localparam logic [7:0] BA_B = 8'd255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [23:0] mem [256];

  logic a_start, a_busy, a_done, a_dout;
  logic [7:0] a_addr;
  logic [23:0] a_data;
  logic b_start, b_busy, b_done, b_dout;
  logic [7:0] b_addr;
  logic [23:0] b_data;

  assign a_data = mem[a_addr];
  assign b_data = mem[b_addr];

  neopixel_tx #(.NUM_PIXELS(NP_A), .BASE_ADDR(BA_A), .T0H(T0H), .T1H(T1H),
                .TBIT(TBIT), .RESET_CYCLES(RST_CYC)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .o_pix_addr(a_addr),
    .i_pix_data(a_data), .o_busy(a_busy), .o_done(a_done), .o_dout(a_dout));

  neopixel_tx #(.NUM_PIXELS(NP_B), .BASE_ADDR(BA_B), .T0H(T0H), .T1H(T1H),
                .TBIT(TBIT), .RESET_CYCLES(RST_CYC)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .o_pix_addr(b_addr),
    .i_pix_data(b_data), .o_busy(b_busy), .o_done(b_done), .o_dout(b_dout));

  typedef struct {
    int         k;
    logic       dout;
    logic       busy;
    logic       done;
    logic       chk;
    logic [7:0] addr;
  } exp_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int k, input logic d, input logic b, input logic dn,
                      input logic c, input logic [7:0] a);
    exp_t e;
    e.k = k; e.dout = d; e.busy = b; e.done = dn; e.chk = c; e.addr = a;
    expq.push_back(e);
  endtask

  // Reference: one item per clock cycle after the edge that accepts the start.
  task automatic push_frame(input int k);
    int np;
    logic [7:0] base;
    np = (k == 0) ? NP_A : NP_B;
    base = (k == 0) ? BA_A : BA_B;
    push(k, 1'b0, 1'b1, 1'b0, 1'b1, base);
    for (int p = 0; p < np; p++) begin
      logic [23:0] w;
      logic [23:0] g;
      w = mem[base + 8'(p)];
      g = {w[15:8], w[23:16], w[7:0]};
      for (int b = 23; b >= 0; b--) begin
        for (int c = 0; c < TBIT; c++) begin
          logic hi;
          logic last;
          hi = (c < (g[b] ? T1H : T0H));
          last = (b == 0) && (c == TBIT - 1) && (p + 1 < np);
          push(k, hi, 1'b1, 1'b0, last, base + 8'(p + 1));
        end
      end
    end
    for (int i = 0; i < RST_CYC; i++) push(k, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    push(k, 1'b0, 1'b0, 1'b1, 1'b1, base);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic have;
    logic [10:0] act;
    logic [7:0] base;
    if (mon_en) begin
      have = (expq.size() > 0);
      if (have) e = expq.pop_front();
      for (int k = 0; k < 2; k++) begin
        act  = (k == 0) ? {a_dout, a_busy, a_done, a_addr} : {b_dout, b_busy, b_done, b_addr};
        base = (k == 0) ? BA_A : BA_B;
        if (have && e.k == k) begin
          check($sformatf("wave%0d {dout,busy,done}", k), 32'(act[10:8]),
                32'({e.dout, e.busy, e.done}));
          if (e.chk) check($sformatf("addr%0d", k), 32'(act[7:0]), 32'(e.addr));
        end else begin
          check($sformatf("idle%0d {dout,busy,done,addr}", k), 32'(act), 32'({3'b000, base}));
        end
      end
    end
  end

  task automatic start_frame(input int k);
    @(negedge clk);
    if (k == 0) a_start = 1'b1; else b_start = 1'b1;
    @(posedge clk);
    push_frame(k);
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected cycles left, required 0", expq.size());
      expq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 24'(i * 24'h010203);
    repeat (3) @(posedge clk);
    #1;
    check("rst a_dout", 32'(a_dout), 32'd0);
    check("rst a_busy", 32'(a_busy), 32'd0);
    check("rst a_done", 32'(a_done), 32'd0);
    check("rst a_addr", 32'(a_addr), 32'(BA_A));
    check("rst b_addr", 32'(b_addr), 32'(BA_B));
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single red pixel: 8 ones framed by 8 zeros on each side in GRB order.
    mem[8] = 24'hFF0000;
    start_frame(0);
    drain(1000);

    // Two pixels across the 255 -> 0 address wrap.
    mem[255] = 24'h000001;
    mem[0]   = 24'h010000;
    start_frame(1);
    drain(1000);

    // Snapshot: overwrite the pixel in flight.
    mem[8] = 24'hA5C33C;
    start_frame(0);
    repeat (20) @(negedge clk);
    mem[8] = 24'h00FF00;
    drain(1000);

    // Reset during bit 10 of pixel 0 aborts the frame.
    mem[8] = 24'h5AA5F0;
    start_frame(0);
    repeat (62) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    expq.delete();
    #1;
    check("abort a_dout", 32'(a_dout), 32'd0);
    check("abort a_busy", 32'(a_busy), 32'd0);
    check("abort a_done", 32'(a_done), 32'd0);
    check("abort a_addr", 32'(a_addr), 32'(BA_A));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    start_frame(0);
    drain(1000);

    // Start held high: second frame begins right after the done cycle, no third.
    mem[8] = 24'h13579B;
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    push_frame(0);
    push_frame(0);
    repeat (1 + NP_A * 24 * TBIT + RST_CYC + 1) @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    drain(1000);

    // Mid-frame start pulse is ignored.
    start_frame(1);
    repeat (50) @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (200) @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    drain(1000);

    // Randomized frames.
    for (int it = 0; it < 12; it++) begin
      int k;
      for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
      k = $urandom_range(0, 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_frame(k);
      drain(1000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
